// File: rtl/gpio_pkg.sv
// Shared sizing constants for the GPIO pad-side logic.
package gpio_pkg;
    localparam int GPIO_NPINS       = 16;
    localparam int GPIO_SYNC_STAGES = 2;
    localparam int GPIO_DEBOUNCE_W  = 8;
endpackage

// File: rtl/gpio_debounce.sv
// One pin's input path: metastability chain, stability counter and filtered value.
// rise is combinational and marks the clock edge on which stable goes 0->1.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
    parameter int DEBOUNCE_W  = GPIO_DEBOUNCE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pad_in,
    input  logic [DEBOUNCE_W-1:0] debounce_limit,
    output logic                  stable,
    output logic                  rise
);
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [DEBOUNCE_W-1:0]  cnt_reg;
    logic [DEBOUNCE_W-1:0]  cnt_next;
    logic                   stable_reg;
    logic                   stable_next;
    logic                   sync_bit;
    logic                   qualify;

    assign sync_bit = sync_reg[SYNC_STAGES-1];

    // >= so that lowering the limit below an in-flight count accepts at once.
    always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        qualify     = 1'b0;
        if (sync_bit == stable_reg) begin
            cnt_next = '0;
        end else if (cnt_reg >= debounce_limit) begin
            stable_next = sync_bit;
            cnt_next    = '0;
            qualify     = 1'b1;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg   <= '0;
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
        end else begin
            sync_reg   <= {sync_reg[SYNC_STAGES-2:0], pad_in};
            cnt_reg    <= cnt_next;
            stable_reg <= stable_next;
        end
    end

    assign stable = stable_reg;
    assign rise   = qualify & sync_bit;
endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad stage: registered pad drive, per-pin debounced inputs,
// rising-edge pending flags and a single registered interrupt line.
module gpio_pad_ctrl
    import gpio_pkg::*;
#(
    parameter int NPINS       = GPIO_NPINS,
    parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
    parameter int DEBOUNCE_W  = GPIO_DEBOUNCE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NPINS-1:0]      rf_gpio_datareg,
    input  logic [NPINS-1:0]      rf_gpio_tristate,
    input  logic [NPINS-1:0]      rf_gpio_interrupt_mask,
    input  logic [DEBOUNCE_W-1:0] debounce_limit,
    input  logic [NPINS-1:0]      irq_clr,
    input  logic [NPINS-1:0]      pad_in,
    output logic [NPINS-1:0]      pad_out,
    output logic [NPINS-1:0]      pad_oe,
    output logic [NPINS-1:0]      ro_gpio_pinstate,
    output logic [NPINS-1:0]      irq_pending,
    output logic                  irq
);
    logic [NPINS-1:0] stable_w;
    logic [NPINS-1:0] rise_w;
    logic [NPINS-1:0] pad_out_reg;
    logic [NPINS-1:0] pad_oe_reg;
    logic [NPINS-1:0] pending_reg;
    logic [NPINS-1:0] pending_next;
    logic             irq_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NPINS; gi++) begin : g_pin
            gpio_debounce #(
                .SYNC_STAGES(SYNC_STAGES),
                .DEBOUNCE_W (DEBOUNCE_W)
            ) u_debounce (
                .clk           (clk),
                .reset         (reset),
                .pad_in        (pad_in[gi]),
                .debounce_limit(debounce_limit),
                .stable        (stable_w[gi]),
                .rise          (rise_w[gi])
            );
        end
    endgenerate

    // Set is ORed in after the clear so a coincident new edge keeps the flag.
    always_comb begin
        pending_next = (pending_reg & ~irq_clr)
                     | (rise_w & rf_gpio_interrupt_mask & ~rf_gpio_tristate);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pad_out_reg <= '0;
            pad_oe_reg  <= '0;
            pending_reg <= '0;
            irq_reg     <= 1'b0;
        end else begin
            pad_out_reg <= rf_gpio_datareg;
            pad_oe_reg  <= rf_gpio_tristate;
            pending_reg <= pending_next;
            irq_reg     <= |(pending_reg & rf_gpio_interrupt_mask);
        end
    end

    assign pad_out          = pad_out_reg;
    assign pad_oe           = pad_oe_reg;
    assign ro_gpio_pinstate = stable_w;
    assign irq_pending      = pending_reg;
    assign irq              = irq_reg;
endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Randomised + directed bench for gpio_pad_ctrl with a queue-based scoreboard.
module tb_gpio_pad_ctrl;
    localparam int NP = 16;
    localparam int SS = 2;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [NP-1:0] datareg, tristate, mask, clr, pad_in;
    logic [DW-1:0] limit;
    logic [NP-1:0] pad_out, pad_oe, pinstate, pending;
    logic          irq;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [NP-1:0] po;
        logic [NP-1:0] oe;
        logic [NP-1:0] ps;
        logic [NP-1:0] pend;
        logic          irq;
    } exp_t;

    exp_t          exp_q[$];
    logic [NP-1:0] pad_hist[$];
    logic [NP-1:0] sync_hist[$];
    logic [NP-1:0] m_stable, m_pend, m_po, m_oe;
    logic          m_irq;

    gpio_pad_ctrl dut (
        .clk                   (clk),
        .reset                 (reset),
        .rf_gpio_datareg       (datareg),
        .rf_gpio_tristate      (tristate),
        .rf_gpio_interrupt_mask(mask),
        .debounce_limit        (limit),
        .irq_clr               (clr),
        .pad_in                (pad_in),
        .pad_out               (pad_out),
        .pad_oe                (pad_oe),
        .ro_gpio_pinstate      (pinstate),
        .irq_pending           (pending),
        .irq                   (irq)
    );

    always #5 clk = ~clk;

    // Reference: a pin's filtered value flips once the last limit+1 synchronised
    // samples all disagree with it; sync is the pad value SS clocks ago.
    task automatic model_edge();
        logic [NP-1:0] sync_now, rise, new_stable, w;
        logic          qual, irq_n;
        exp_t          e;
        if (reset) begin
            m_stable = '0; m_pend = '0; m_po = '0; m_oe = '0; m_irq = 1'b0;
            pad_hist.delete();
            sync_hist.delete();
        end else begin
            sync_now = (pad_hist.size() >= SS) ? pad_hist[SS-1] : '0;
            pad_hist.push_front(pad_in);
            if (pad_hist.size() > SS) void'(pad_hist.pop_back());
            sync_hist.push_front(sync_now);
            if (sync_hist.size() > 300) void'(sync_hist.pop_back());
            irq_n = |(m_pend & mask);
            rise = '0;
            new_stable = m_stable;
            for (int i = 0; i < NP; i++) begin
                qual = (sync_hist.size() >= int'(limit) + 1);
                for (int k = 0; k <= int'(limit) && qual; k++) begin
                    w = sync_hist[k];
                    if (w[i] == m_stable[i]) qual = 1'b0;
                end
                if (qual) begin
                    if (sync_now[i] && !m_stable[i]) rise[i] = 1'b1;
                    new_stable[i] = sync_now[i];
                end
            end
            m_pend   = (m_pend & ~clr) | (rise & mask & ~tristate);
            m_stable = new_stable;
            m_po     = datareg;
            m_oe     = tristate;
            m_irq    = irq_n;
        end
        e.po = m_po; e.oe = m_oe; e.ps = m_stable; e.pend = m_pend; e.irq = m_irq;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic check_eq(input string name, input logic [NP-1:0] act, input logic [NP-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard monitor: one comparison per clock once stimulus has started.
    always @(posedge clk) begin
        exp_t e, a;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a.po = pad_out; a.oe = pad_oe; a.ps = pinstate; a.pend = pending; a.irq = irq;
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL scoreboard t=%0t: got out=%h oe=%h ps=%h pend=%h irq=%b expected out=%h oe=%h ps=%h pend=%h irq=%b",
                         $time, a.po, a.oe, a.ps, a.pend, a.irq, e.po, e.oe, e.ps, e.pend, e.irq);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset = 1'b1; datareg = '0; tristate = '0; mask = '0; clr = '0;
        pad_in = 16'hFFFF; limit = 8'd3;

        // Reset with pads high: everything held at zero.
        run(3);
        check_eq("reset_pinstate", pinstate, 16'h0000);
        check_eq("reset_pad_oe", pad_oe, 16'h0000);
        reset = 1'b0;
        run(1);
        check_eq("release_pinstate", pinstate, 16'h0000);
        pad_in = 16'h0000;
        run(8);

        // Output drive latency and debounce latency.
        datareg = 16'h1234; tristate = 16'h0004;
        run(1);
        check_eq("pad_out_1clk", pad_out, 16'h1234);
        check_eq("pad_oe_1clk", pad_oe, 16'h0004);
        pad_in[0] = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            step();
            check_eq($sformatf("latency_pin0_clk%0d", n), {15'd0, pinstate[0]}, (n == 6) ? 16'h1 : 16'h0);
        end

        // Glitch rejection then acceptance on pin 5.
        pad_in[5] = 1'b1; run(3); pad_in[5] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            step();
            if (pinstate[5] || pending[5]) seen = 1'b1;
        end
        check_eq("glitch3_rejected", {15'd0, seen}, 16'h0);
        pad_in[5] = 1'b1; run(4); pad_in[5] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            step();
            if (pinstate[5]) seen = 1'b1;
        end
        check_eq("glitch4_accepted", {15'd0, seen}, 16'h1);

        // Masked rising edge raises pending and irq; unmasked pin does not.
        tristate = 16'h0000; pad_in[0] = 1'b0; run(8);
        mask = 16'h0001; pad_in[0] = 1'b1; run(6);
        check_eq("pending_pin0", pending, 16'h0001);
        run(1);
        check_eq("irq_after_pending", {15'd0, irq}, 16'h1);
        pad_in[1] = 1'b1; run(8);
        check_eq("unmasked_pin1", pending, 16'h0001);

        // Clear coinciding with a new rise: set wins.
        pad_in[0] = 1'b0; run(8);
        pad_in[0] = 1'b1; run(5);
        clr = 16'h0001; run(1); clr = 16'h0000;
        check_eq("clear_race_pending", pending, 16'h0001);
        run(2);
        clr = 16'h0001; run(1); clr = 16'h0000;
        check_eq("lone_clear_pending", pending, 16'h0000);
        run(1);
        check_eq("lone_clear_irq", {15'd0, irq}, 16'h0);

        // Driven pin: pinstate follows the pad, pending never set.
        tristate = 16'h0004; mask = 16'h0005; pad_in[2] = 1'b1; run(6);
        check_eq("driven_pinstate2", {15'd0, pinstate[2]}, 16'h1);
        check_eq("driven_pending2", {15'd0, pending[2]}, 16'h0);

        // Randomised traffic including limit changes and mid-run resets.
        for (int c = 0; c < 2500; c++) begin
            datareg = 16'($urandom);
            clr     = 16'($urandom & $urandom & $urandom & $urandom);
            pad_in  = pad_in ^ 16'($urandom & $urandom & $urandom);
            if (c % 40 == 0) begin
                mask     = 16'($urandom);
                tristate = 16'($urandom & $urandom);
            end
            if (c % 150 == 0) limit = 8'($urandom_range(0, 5));
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        run(2);
        #10;
        check_eq("scoreboard_drained", 16'(exp_q.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
